// File: rtl/perceptron_pkg.sv
// Shared widths, error encodings, saturation limits and the FIFO result
// record for the perceptron activation stage.
package perceptron_pkg;

    localparam int SUM_W  = 48;
    localparam int DATA_W = 16;
    localparam int BSUM_W = SUM_W + 1;
    localparam int RES_W  = DATA_W + 3;

    typedef enum logic [1:0] {
        ERR_ZERO = 2'b00,
        ERR_POS  = 2'b01,
        ERR_NEG  = 2'b11
    } err_t;

    localparam logic signed [DATA_W-1:0] ACT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] ACT_MIN = 16'sh8000;

    typedef struct packed {
        logic signed [DATA_W-1:0] act;
        logic                     y;
        err_t                     err;
    } result_t;

    // Clamp a wide scaled sum into the signed 16-bit activation range.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [BSUM_W-1:0] s);
        logic signed [BSUM_W-1:0] hi;
        logic signed [BSUM_W-1:0] lo;
        hi = {{(BSUM_W-DATA_W){ACT_MAX[DATA_W-1]}}, ACT_MAX};
        lo = {{(BSUM_W-DATA_W){ACT_MIN[DATA_W-1]}}, ACT_MIN};
        if (s > hi) begin
            return ACT_MAX;
        end else if (s < lo) begin
            return ACT_MIN;
        end
        return s[DATA_W-1:0];
    endfunction

    // Training error label - y for one-bit label and step output.
    function automatic err_t label_error(input logic label, input logic y);
        case ({label, y})
            2'b10:   return ERR_POS;
            2'b01:   return ERR_NEG;
            default: return ERR_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/perceptron_activation_if.sv
// Ready/valid result stream leaving the activation stage.
interface perceptron_activation_if;
    import perceptron_pkg::*;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_act;
    logic                     out_y;
    logic [1:0]               out_err;

    modport master (
        output out_valid,
        output out_act,
        output out_y,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_act,
        input  out_y,
        input  out_err,
        output out_ready
    );

endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO for activation results. A push into a full FIFO
// succeeds only when a pop happens in the same cycle.
module result_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/perceptron_activation.sv
// Activation stage of the single-perceptron datapath: re-times valid/label
// against the weighted-sum pipeline, adds bias, scales and saturates, applies
// a step activation, computes training error and buffers results.
module perceptron_activation
    import perceptron_pkg::*;
#(
    parameter int SUM_LATENCY = 11,
    parameter int FRAC_SHIFT  = 14,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_label,
    input  logic signed [SUM_W-1:0] sum,
    input  logic signed [SUM_W-1:0] bias,
    input  logic                    clr_stats,
    perceptron_activation_if.master res,
    output logic [31:0]             sample_count,
    output logic [31:0]             error_count,
    output logic                    overflow
);

    logic [SUM_LATENCY-1:0]    dl_valid;
    logic [SUM_LATENCY-1:0]    dl_label;
    logic                      tap_valid;
    logic                      tap_label;

    logic                      s1_valid;
    logic                      s1_label;
    logic signed [BSUM_W-1:0]  s1_sum;
    result_t                   s1_result;

    logic                      s2_valid;
    result_t                   s2_res;

    logic [RES_W-1:0]          fifo_head_bits;
    result_t                   head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      pop_req;
    logic                      write_ok;

    assign tap_valid = dl_valid[SUM_LATENCY-1];
    assign tap_label = dl_label[SUM_LATENCY-1];

    // Delay line carrying launch-side valid and label until the sum arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
            dl_label <= '0;
        end else begin
            for (int i = SUM_LATENCY - 1; i > 0; i--) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_label[i] <= dl_label[i-1];
            end
            dl_valid[0] <= in_valid;
            dl_label[0] <= in_label;
        end
    end

    // Stage 1: widen by one bit so adding the bias can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_label <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= tap_valid;
            s1_label <= tap_label;
            if (tap_valid) begin
                s1_sum <= {sum[SUM_W-1], sum} + {bias[SUM_W-1], bias};
            end
        end
    end

    // Scale, saturate, step and error for the stage-1 value.
    always_comb begin
        s1_result     = '0;
        s1_result.act = saturate(s1_sum >>> FRAC_SHIFT);
        s1_result.y   = ~s1_sum[BSUM_W-1];
        s1_result.err = label_error(s1_label, ~s1_sum[BSUM_W-1]);
    end

    // Stage 2: register the finished result ahead of the FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= s1_result;
            end
        end
    end

    assign pop_req  = !fifo_empty && res.out_ready;
    assign write_ok = s2_valid && (!fifo_full || pop_req);

    result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s2_valid),
        .wr_data (s2_res),
        .pop     (pop_req),
        .rd_data (fifo_head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head = result_t'(fifo_head_bits);

    // Present the FIFO head; outputs read as zero while nothing is buffered.
    always_comb begin
        res.out_valid = (fifo_count != '0);
        res.out_act   = '0;
        res.out_y     = 1'b0;
        res.out_err   = ERR_ZERO;
        if (fifo_count != '0) begin
            res.out_act = head.act;
            res.out_y   = head.y;
            res.out_err = head.err;
        end
    end

    // Saturating statistics and sticky overflow; a clear beats any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count <= '0;
            error_count  <= '0;
            overflow     <= 1'b0;
        end else if (clr_stats) begin
            sample_count <= '0;
            error_count  <= '0;
            overflow     <= 1'b0;
        end else begin
            if (write_ok) begin
                if (sample_count != '1) begin
                    sample_count <= sample_count + 32'd1;
                end
                if ((s2_res.err != ERR_ZERO) && (error_count != '1)) begin
                    error_count <= error_count + 32'd1;
                end
            end
            if (s2_valid && !write_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/perceptron_activation.md
# perceptron_activation

Downstream companion of the DSP weighted-sum stage in the single-perceptron datapath. It receives the raw 48-bit weighted sum and re-times the launch-side valid and label through a delay line matched to the sum pipeline. It then adds a bias, scales and saturates the result to 16-bit fixed point, applies a step activation, computes the training error against the label, and buffers results in a small FIFO for a ready/valid consumer. Running sample and error counters support on-board training demos.

## Interface
- SUM_LATENCY, 11: cycles from x/w launch into the sum stage to the matching `sum` value (N=8 configuration).
- FRAC_SHIFT, 14: arithmetic right shift applied to the biased sum (Q1.14 × Q1.14 → Q1.14).
- FIFO_DEPTH, 4: result FIFO entries; power of two, ≥2.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  asserted in the cycle x/w are launched into the sum stage.
- in_label  in  1  target class for that sample (1 = positive).
- sum  in  48  signed weighted sum from the sum stage.
- bias  in  48  signed bias, quasi-static; sampled every cycle.
- clr_stats  in  1  single-cycle clear of counters and overflow flag.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when high with out_valid.
- out_act  out  16  signed saturated activation input.
- out_y  out  1  step output.
- out_err  out  2  label − y, two's complement: 2'b00 = 0, 2'b01 = +1, 2'b11 = −1.
- sample_count  out  32  results written to the FIFO.
- error_count  out  32  written results with out_err ≠ 0.
- overflow  out  1  sticky; a result was dropped on a full FIFO.

## Operation
- Delay line: {in_valid, in_label} pass through a SUM_LATENCY-deep shift register. The tap aligns with `sum`. `sum` is ignored when the tap valid is 0.
- Stage 1: b = sext49(sum) + sext49(bias), registered with its valid and label. No wrap is possible.
- Stage 2, registered:
  - s = b >>> FRAC_SHIFT.
  - out_act = s clamped to [−32768, 32767].
  - y = (b ≥ 0). A zero sum gives y = 1.
  - err = label − y.
- Write: a stage-2 valid writes {act, y, err} to the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the result is dropped, overflow is set, and no counter changes.
  - A pop and a push in the same cycle on a full FIFO both succeed.
- Counters increment on each accepted write and saturate at 2^32−1.
- clr_stats zeroes both counters and overflow. It wins over a same-cycle increment or overflow set.
- FIFO: head is presented on out_* whenever count > 0. It pops on out_valid && out_ready. Pointers wrap modulo FIFO_DEPTH. There is no empty-to-output bypass.
- Reset state:
  - The delay line, stage valids, FIFO pointers and count, counters and overflow are all 0.
  - out_valid = 0 and out_act/out_y/out_err = 0.
  - In-flight samples are discarded. Samples launched in the SUM_LATENCY cycles before rst deassertion are lost.

## Timing
- in_valid at cycle t: sum sampled at t+SUM_LATENCY, stage 1 at t+SUM_LATENCY+1, stage 2 / FIFO write at t+SUM_LATENCY+2.
- out_valid rises at t+SUM_LATENCY+3 when the FIFO was empty.
- Throughput is one result per cycle while out_ready is held high.
- Counters and overflow update in the same edge as the FIFO write.
- out_* are stable while out_valid && !out_ready.

## Structure
- Package `perceptron_pkg`:
  - SUM_W = 48, DATA_W = 16.
  - ERR_ZERO/ERR_POS/ERR_NEG encodings.
  - ACT_MAX/ACT_MIN saturation constants.
  - Result record width (DATA_W + 3).
- Sub-module `result_fifo`: synchronous FIFO with parameters WIDTH and DEPTH, and ports push/pop/full/empty/count. It is kept separate from the existing delay-line fifo.
- The delay line, pipeline, saturation and counters are inline in the top.

## Test plan
- sum = 0x0000_1000_0000, bias = 0, label = 1 → out_act = 0x4000, y = 1, err = 00; out_valid exactly SUM_LATENCY+3 cycles after in_valid.
- sum = −2^28, bias = 0, label = 1 → out_act = 0xC000, y = 0, err = 01, error_count = 1.
- Saturation:
  - sum = 2^40 → out_act = 0x7FFF, y = 1.
  - sum = −2^40, label = 0 → 0x8000, y = 0, err = 00.
- Bias boundary:
  - sum = −5, bias = 5 → out_act = 0, y = 1.
  - bias = 4 → y = 0, out_act = 0xFFFF.
- Backpressure:
  - out_ready = 0 and 5 back-to-back valids → 4 results held, overflow = 1, sample_count = 4.
  - Release → heads pop in order.
  - clr_stats → counters and overflow return to 0.
- Reset mid-stream: rst asserted for 1 cycle with 3 samples in flight and 2 buffered → out_valid = 0 next cycle, the in-flight samples never appear, counters = 0.
